// File: rtl/ss_access_scheduler_pkg.sv
// Shared types and width helpers for the subsystem access scheduler.
package ss_access_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        DRAIN   = 2'd2
    } ss_sched_state_t;

    // Width of an index selecting one of n items (at least one bit).
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold values 0..m inclusive.
    function automatic int cnt_bits(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ss_access_scheduler_if.sv
// Bundle of per-group handshakes and scheduler outputs.
// master: the AXI channel monitor / interconnect side; slave: the scheduler.
interface ss_access_scheduler_if #(
    parameter int NUM_PORTS     = 4,
    parameter int PORT_IDX_BITS = 2,
    parameter int CNT_BITS      = 3
);
    logic [NUM_PORTS-1:0]     arvalid;
    logic [NUM_PORTS-1:0]     arready;
    logic [NUM_PORTS-1:0]     awvalid;
    logic [NUM_PORTS-1:0]     awready;
    logic [NUM_PORTS-1:0]     rvalid;
    logic [NUM_PORTS-1:0]     rready;
    logic [NUM_PORTS-1:0]     rlast;
    logic [NUM_PORTS-1:0]     bvalid;
    logic [NUM_PORTS-1:0]     bready;
    logic [NUM_PORTS-1:0]     port_enable;
    logic                     err_clear;
    logic [PORT_IDX_BITS-1:0] group_select;
    logic                     grant_valid;
    logic                     ar_allow;
    logic                     aw_allow;
    logic [CNT_BITS-1:0]      outstanding;
    logic                     timeout_err;
    logic [PORT_IDX_BITS-1:0] timeout_port;

    modport master (
        output arvalid, arready, awvalid, awready,
        output rvalid, rready, rlast, bvalid, bready,
        output port_enable, err_clear,
        input  group_select, grant_valid, ar_allow, aw_allow,
        input  outstanding, timeout_err, timeout_port
    );

    modport slave (
        input  arvalid, arready, awvalid, awready,
        input  rvalid, rready, rlast, bvalid, bready,
        input  port_enable, err_clear,
        output group_select, grant_valid, ar_allow, aw_allow,
        output outstanding, timeout_err, timeout_port
    );
endinterface

// File: rtl/ss_access_scheduler_arb.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted index and wraps, so the previous winner has lowest priority.
module ss_rr_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int PORT_IDX_BITS = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]     requests_i,
    input  logic [PORT_IDX_BITS-1:0] last_grant_i,
    output logic [PORT_IDX_BITS-1:0] grant_idx_o,
    output logic                     grant_vld_o
);

    // First requester found after last_grant_i, in wrap-around order.
    always_comb begin
        int                       p;
        logic [PORT_IDX_BITS-1:0] pi;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            p  = (int'(last_grant_i) + k) % NUM_PORTS;
            pi = PORT_IDX_BITS'(p);
            if (!grant_vld_o && requests_i[pi]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = pi;
            end
        end
    end

endmodule

// File: rtl/ss_access_scheduler.sv
// Multi-outstanding subsystem access scheduler: round-robin group grant,
// up to MAX_OUTSTANDING in-flight transactions and QUANTUM address
// handshakes per grant, then drain before re-arbitrating.
// Optional watchdog enabled by defining SS_ACCESS_TIMEOUT_EN.
module ss_access_scheduler
    import ss_access_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int PORT_IDX_BITS   = idx_bits(NUM_PORTS),
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_BITS        = cnt_bits(MAX_OUTSTANDING),
    parameter int QUANTUM         = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic                 clk,
    input logic                 reset_n,
    ss_access_scheduler_if.slave bus
);

    localparam int ISS_BITS = cnt_bits(QUANTUM);
    localparam int OW       = CNT_BITS + 1;

    localparam logic [CNT_BITS-1:0] MAX_CNT  = CNT_BITS'(MAX_OUTSTANDING);
    localparam logic [CNT_BITS-1:0] MAX_M1   = CNT_BITS'(MAX_OUTSTANDING - 1);
    localparam logic [ISS_BITS-1:0] QUANT    = ISS_BITS'(QUANTUM);
    localparam logic [ISS_BITS-1:0] QUANT_M1 = ISS_BITS'(QUANTUM - 1);
    localparam logic [PORT_IDX_BITS-1:0] LAST_RST = PORT_IDX_BITS'(NUM_PORTS - 1);

    ss_sched_state_t          state_q, state_d;
    logic [PORT_IDX_BITS-1:0] sel_q, sel_d;
    logic [PORT_IDX_BITS-1:0] last_q, last_d;
    logic [CNT_BITS-1:0]      out_q, out_d;
    logic [ISS_BITS-1:0]      iss_q, iss_d;

    logic [NUM_PORTS-1:0]     req;
    logic [PORT_IDX_BITS-1:0] arb_idx;
    logic                     arb_vld;

    logic                     ar_ok, aw_ok;
    logic                     ar_hs, aw_hs;
    logic [1:0]               inc, dec_raw;
    logic [CNT_BITS-1:0]      out_nx;
    logic [ISS_BITS-1:0]      iss_nx;

    assign req = (bus.arvalid | bus.awvalid) & bus.port_enable;

    ss_rr_arbiter #(
        .NUM_PORTS     (NUM_PORTS),
        .PORT_IDX_BITS (PORT_IDX_BITS)
    ) u_arb (
        .requests_i   (req),
        .last_grant_i (last_q),
        .grant_idx_o  (arb_idx),
        .grant_vld_o  (arb_vld)
    );

    // Address-phase permission; AR keeps the last free slot when both contend.
    always_comb begin
        ar_ok = (state_q == GRANTED) && (out_q < MAX_CNT) && (iss_q < QUANT);
        aw_ok = ar_ok && !(bus.arvalid[sel_q] && ((out_q == MAX_M1) || (iss_q == QUANT_M1)));
        ar_hs = ar_ok && bus.arvalid[sel_q] && bus.arready[sel_q];
        aw_hs = aw_ok && bus.awvalid[sel_q] && bus.awready[sel_q];
    end

    // Outstanding/issued arithmetic; completions beyond the count are dropped.
    always_comb begin
        logic [OW-1:0] out_ext;
        logic [OW-1:0] dec_ext;
        logic [OW-1:0] sum_ext;
        inc     = 2'(ar_hs) + 2'(aw_hs);
        dec_raw = 2'(bus.rvalid[sel_q] & bus.rready[sel_q] & bus.rlast[sel_q])
                + 2'(bus.bvalid[sel_q] & bus.bready[sel_q]);
        out_ext = {1'b0, out_q};
        dec_ext = OW'(dec_raw);
        if (dec_ext > out_ext) begin
            dec_ext = out_ext;
        end
        sum_ext = out_ext + OW'(inc) - dec_ext;
        out_nx  = sum_ext[CNT_BITS-1:0];
        iss_nx  = iss_q + ISS_BITS'(inc);
    end

`ifdef SS_ACCESS_TIMEOUT_EN
    localparam int WD_BITS = cnt_bits(TIMEOUT_CYCLES);
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

    logic [WD_BITS-1:0]       wd_q, wd_d;
    logic                     err_q, err_d;
    logic [PORT_IDX_BITS-1:0] tport_q, tport_d;
    logic                     any_hs;
    logic                     fire;

    // Watchdog: counts stalled cycles while the granted group has traffic in flight.
    always_comb begin
        any_hs = ar_hs || aw_hs
              || (bus.rvalid[sel_q] && bus.rready[sel_q])
              || (bus.bvalid[sel_q] && bus.bready[sel_q]);
        fire = 1'b0;
        wd_d = '0;
        if ((state_q != IDLE) && (out_q != '0) && !any_hs) begin
            if (wd_q == WD_LAST) begin
                fire = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
        err_d   = fire | (err_q & ~bus.err_clear);
        tport_d = fire ? sel_q : tport_q;
    end

    // Watchdog state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            err_q   <= 1'b0;
            tport_q <= '0;
        end else begin
            wd_q    <= wd_d;
            err_q   <= err_d;
            tport_q <= tport_d;
        end
    end

    assign bus.timeout_err  = err_q;
    assign bus.timeout_port = tport_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_err_clear;
    assign unused_err_clear = bus.err_clear;
    assign bus.timeout_err  = 1'b0;
    assign bus.timeout_port = '0;
`endif

    // Grant FSM next-state: arbitrate, issue, drain, then re-arbitrate or idle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        out_d   = out_q;
        iss_d   = iss_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = GRANTED;
                    sel_d   = arb_idx;
                    last_d  = arb_idx;
                    iss_d   = '0;
                end
            end
            GRANTED: begin
                out_d = out_nx;
                iss_d = iss_nx;
                if ((iss_nx == QUANT) || !req[sel_q]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    if (arb_vld) begin
                        state_d = GRANTED;
                        sel_d   = arb_idx;
                        last_d  = arb_idx;
                        iss_d   = '0;
                    end else begin
                        state_d = IDLE;
                        sel_d   = '0;
                    end
                end else begin
                    out_d = out_nx;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                out_d   = '0;
                iss_d   = '0;
            end
        endcase
`ifdef SS_ACCESS_TIMEOUT_EN
        if (fire) begin
            state_d = IDLE;
            sel_d   = '0;
            out_d   = '0;
            iss_d   = '0;
        end
`endif
    end

    // Grant FSM and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= LAST_RST;
            out_q   <= '0;
            iss_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            out_q   <= out_d;
            iss_q   <= iss_d;
        end
    end

    assign bus.group_select = sel_q;
    assign bus.grant_valid  = (state_q != IDLE);
    assign bus.ar_allow     = ar_ok;
    assign bus.aw_allow     = aw_ok;
    assign bus.outstanding  = out_q;

endmodule

// File: tb/tb_ss_access_scheduler.sv
// Directed bench for ss_access_scheduler with a behavioural reference model.
module tb_ss_access_scheduler;

    localparam int NP  = 4;
    localparam int PIB = 2;
    localparam int MO  = 4;
    localparam int CB  = 3;
    localparam int QT  = 8;
    localparam int TO  = 16;

    localparam int M_IDLE    = 0;
    localparam int M_GRANTED = 1;
    localparam int M_DRAIN   = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ss_access_scheduler_if #(.NUM_PORTS(NP), .PORT_IDX_BITS(PIB), .CNT_BITS(CB)) bus ();

    ss_access_scheduler #(
        .NUM_PORTS       (NP),
        .PORT_IDX_BITS   (PIB),
        .MAX_OUTSTANDING (MO),
        .CNT_BITS        (CB),
        .QUANTUM         (QT),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_st, m_sel, m_last, m_out, m_iss, m_err, m_port, m_wd;

    function automatic int rr_pick(input logic [NP-1:0] r, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (r[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model_cmp
        logic [NP-1:0]  req;
        logic [PIB-1:0] s;
        bit ar_ok, aw_ok, arh, awh, anyhs, fire;
        int inc, dec, o_out, w;
        if (!reset_n) begin
            m_st = M_IDLE; m_sel = 0; m_last = NP - 1; m_out = 0; m_iss = 0;
            m_err = 0; m_port = 0; m_wd = 0;
        end
        s     = PIB'(m_sel);
        req   = (bus.arvalid | bus.awvalid) & bus.port_enable;
        ar_ok = (m_st == M_GRANTED) && (m_out < MO) && (m_iss < QT);
        aw_ok = ar_ok && !(bus.arvalid[s] && ((MO - m_out == 1) || (QT - m_iss == 1)));

        check("model grant_valid", 32'(bus.grant_valid), 32'(m_st != M_IDLE));
        check("model group_select", 32'(bus.group_select), 32'(m_sel));
        check("model outstanding", 32'(bus.outstanding), 32'(m_out));
        check("model ar_allow", 32'(bus.ar_allow), 32'(ar_ok));
        check("model aw_allow", 32'(bus.aw_allow), 32'(aw_ok));
        check("model timeout_err", 32'(bus.timeout_err), 32'(m_err));
        check("model timeout_port", 32'(bus.timeout_port), 32'(m_port));

        if (reset_n) begin
            arh  = ar_ok && bus.arvalid[s] && bus.arready[s];
            awh  = aw_ok && bus.awvalid[s] && bus.awready[s];
            inc  = int'(arh) + int'(awh);
            dec  = 0;
            if (m_st != M_IDLE)
                dec = int'(bus.rvalid[s] & bus.rready[s] & bus.rlast[s])
                    + int'(bus.bvalid[s] & bus.bready[s]);
            if (dec > m_out) dec = m_out;
            fire = 1'b0;
`ifdef SS_ACCESS_TIMEOUT_EN
            anyhs = arh || awh || (bus.rvalid[s] && bus.rready[s]) || (bus.bvalid[s] && bus.bready[s]);
            if ((m_st != M_IDLE) && (m_out > 0) && !anyhs) begin
                m_wd++;
                if (m_wd >= TO) begin fire = 1'b1; m_wd = 0; end
            end else begin
                m_wd = 0;
            end
            if (bus.err_clear) m_err = 0;
`else
            anyhs = 1'b0;
`endif
            o_out = m_out;
            case (m_st)
                M_IDLE: begin
                    w = rr_pick(req, m_last);
                    if (w >= 0) begin m_st = M_GRANTED; m_sel = w; m_last = w; m_iss = 0; end
                end
                M_GRANTED: begin
                    m_out = o_out + inc - dec;
                    m_iss = m_iss + inc;
                    if ((m_iss == QT) || !req[s]) m_st = M_DRAIN;
                end
                default: begin
                    if (o_out == 0) begin
                        w = rr_pick(req, m_last);
                        if (w >= 0) begin m_st = M_GRANTED; m_sel = w; m_last = w; m_iss = 0; end
                        else begin m_st = M_IDLE; m_sel = 0; end
                    end else begin
                        m_out = o_out - dec;
                    end
                end
            endcase
            if (fire) begin
                m_err = 1; m_port = m_sel; m_st = M_IDLE; m_sel = 0; m_out = 0; m_iss = 0;
            end
        end
    end

    // ---------------- grant-order observer ----------------
    int gq[$];
    int hq[$];
    bit prev_gv = 1'b0;
    int prev_sel = 0;

    always @(negedge clk) begin : observer
        logic [PIB-1:0] s;
        s = bus.group_select;
        if (!reset_n) begin
            prev_gv = 1'b0;
        end else begin
            if (bus.grant_valid && (!prev_gv || int'(s) != prev_sel)) begin
                gq.push_back(int'(s));
                hq.push_back(0);
            end
            if (bus.grant_valid && hq.size() > 0) begin
                if (bus.ar_allow && bus.arvalid[s] && bus.arready[s]) hq[hq.size()-1]++;
                if (bus.aw_allow && bus.awvalid[s] && bus.awready[s]) hq[hq.size()-1]++;
            end
            prev_gv  = bus.grant_valid;
            prev_sel = int'(s);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_inputs();
        bus.arvalid = '0; bus.arready = '0; bus.awvalid = '0; bus.awready = '0;
        bus.rvalid  = '0; bus.rready  = '0; bus.rlast   = '0;
        bus.bvalid  = '0; bus.bready  = '0;
        bus.port_enable = '1; bus.err_clear = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got 0 expected 1");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        int waited;
        int ones;
        int exp3[4];
        int exp5[4];
        exp3 = '{0, 3, 0, 3};
        exp5 = '{0, 2, 3, 0};

        clear_inputs();
        reset_n = 1'b0;
        tick(2);
        check("reset grant_valid", 32'(bus.grant_valid), 32'd0);
        check("reset group_select", 32'(bus.group_select), 32'd0);
        check("reset outstanding", 32'(bus.outstanding), 32'd0);
        check("reset ar_allow", 32'(bus.ar_allow), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // single AR on port 2, one read completion, back to idle
        bus.arvalid[2] = 1'b1; bus.arready[2] = 1'b1;
        tick(1);
        check("t1 grant_valid", 32'(bus.grant_valid), 32'd1);
        check("t1 group_select", 32'(bus.group_select), 32'd2);
        check("t1 ar_allow", 32'(bus.ar_allow), 32'd1);
        tick(1);
        bus.arvalid[2] = 1'b0; bus.arready[2] = 1'b0;
        check("t1 outstanding after AR", 32'(bus.outstanding), 32'd1);
        bus.rvalid[2] = 1'b1; bus.rready[2] = 1'b1; bus.rlast[2] = 1'b1;
        tick(1);
        bus.rvalid[2] = 1'b0; bus.rready[2] = 1'b0; bus.rlast[2] = 1'b0;
        check("t1 outstanding after R", 32'(bus.outstanding), 32'd0);
        check("t1 drain grant_valid", 32'(bus.grant_valid), 32'd1);
        tick(1);
        check("t1 idle grant_valid", 32'(bus.grant_valid), 32'd0);
        check("t1 idle group_select", 32'(bus.group_select), 32'd0);

        // five back-to-back ARs on port 1 against an outstanding limit of 4
        do_reset();
        bus.arvalid[1] = 1'b1; bus.arready[1] = 1'b1;
        tick(5);
        check("t2 outstanding at limit", 32'(bus.outstanding), 32'd4);
        check("t2 ar_allow at limit", 32'(bus.ar_allow), 32'd0);
        bus.rvalid[1] = 1'b1; bus.rready[1] = 1'b1; bus.rlast[1] = 1'b1;
        tick(1);
        bus.rvalid[1] = 1'b0; bus.rready[1] = 1'b0; bus.rlast[1] = 1'b0;
        check("t2 outstanding after R", 32'(bus.outstanding), 32'd3);
        check("t2 ar_allow reopened", 32'(bus.ar_allow), 32'd1);
        tick(1);
        check("t2 fifth AR accepted", 32'(bus.outstanding), 32'd4);
        bus.arvalid[1] = 1'b0;
        bus.rvalid[1] = 1'b1; bus.rready[1] = 1'b1; bus.rlast[1] = 1'b1;
        tick(4);
        bus.rvalid[1] = 1'b0; bus.rready[1] = 1'b0; bus.rlast[1] = 1'b0;
        tick(2);
        check("t2 back to idle", 32'(bus.grant_valid), 32'd0);

        // ports 0 and 3 streaming: quantum of 8 each, alternating grants
        do_reset();
        gq.delete(); hq.delete();
        bus.arvalid = 4'b1001; bus.arready = 4'b1001;
        bus.rvalid = 4'b1001; bus.rready = 4'b1001; bus.rlast = 4'b1001;
        tick(50);
        bus.arvalid = '0;
        tick(8);
        check("t3 grant count", 32'(gq.size() >= 4), 32'd1);
        if (gq.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("t3 order[%0d]", i), 32'(gq[i]), 32'(exp3[i]));
            for (int i = 0; i < 3; i++) check($sformatf("t3 quantum[%0d]", i), 32'(hq[i]), 32'd8);
        end

        // AR wins the last slot over AW; AR plus B completion keeps the count
        do_reset();
        bus.arvalid[0] = 1'b1; bus.arready[0] = 1'b1;
        tick(4);
        bus.awvalid[0] = 1'b1; bus.awready[0] = 1'b1;
        #1;
        check("t4 outstanding 3", 32'(bus.outstanding), 32'd3);
        check("t4 aw_allow blocked", 32'(bus.aw_allow), 32'd0);
        check("t4 ar_allow open", 32'(bus.ar_allow), 32'd1);
        tick(1);
        check("t4 only AR counted", 32'(bus.outstanding), 32'd4);
        bus.arvalid[0] = 1'b0; bus.awready[0] = 1'b0;
        bus.rvalid[0] = 1'b1; bus.rready[0] = 1'b1; bus.rlast[0] = 1'b1;
        tick(2);
        bus.rvalid[0] = 1'b0; bus.rready[0] = 1'b0; bus.rlast[0] = 1'b0;
        check("t4 outstanding 2", 32'(bus.outstanding), 32'd2);
        bus.arvalid[0] = 1'b1; bus.bvalid[0] = 1'b1; bus.bready[0] = 1'b1;
        #1;
        check("t4 ar_allow at 2", 32'(bus.ar_allow), 32'd1);
        tick(1);
        bus.bvalid[0] = 1'b0; bus.bready[0] = 1'b0;
        check("t4 AR+B net zero", 32'(bus.outstanding), 32'd2);
        reset_n = 1'b0;
        #1;
        check("t4 async reset outstanding", 32'(bus.outstanding), 32'd0);
        check("t4 async reset grant_valid", 32'(bus.grant_valid), 32'd0);

        // port 1 masked: rotation 0,2,3,0
        do_reset();
        gq.delete(); hq.delete();
        bus.port_enable = 4'b1101;
        bus.arvalid = '1; bus.arready = '1;
        bus.rvalid = '1; bus.rready = '1; bus.rlast = '1;
        tick(50);
        clear_inputs();
        tick(8);
        check("t5 grant count", 32'(gq.size() >= 4), 32'd1);
        if (gq.size() >= 4)
            for (int i = 0; i < 4; i++) check($sformatf("t5 order[%0d]", i), 32'(exp5[i]), 32'(gq[i]) == 32'(exp5[i]) ? 32'(exp5[i]) : 32'(gq[i]));
        ones = 0;
        foreach (gq[i]) if (gq[i] == 1) ones++;
        check("t5 port1 grants", 32'(ones), 32'd0);

        // stalled read on port 1
        do_reset();
        bus.arvalid[1] = 1'b1; bus.arready[1] = 1'b1;
        tick(2);
        bus.arvalid[1] = 1'b0; bus.arready[1] = 1'b0;
        check("t6 outstanding 1", 32'(bus.outstanding), 32'd1);
        waited = 0;
        while (!bus.timeout_err && waited < 40) begin
            tick(1);
            waited++;
        end
`ifdef SS_ACCESS_TIMEOUT_EN
        check("t6 cycles to timeout", 32'(waited), 32'd16);
        check("t6 timeout_err", 32'(bus.timeout_err), 32'd1);
        check("t6 timeout_port", 32'(bus.timeout_port), 32'd1);
        check("t6 outstanding cleared", 32'(bus.outstanding), 32'd0);
        check("t6 grant dropped", 32'(bus.grant_valid), 32'd0);
        bus.err_clear = 1'b1;
        tick(1);
        bus.err_clear = 1'b0;
        check("t6 err cleared", 32'(bus.timeout_err), 32'd0);
`else
        check("t6 no timeout_err", 32'(bus.timeout_err), 32'd0);
        check("t6 grant held", 32'(bus.grant_valid), 32'd1);
        check("t6 outstanding held", 32'(bus.outstanding), 32'd1);
        check("t6 group held", 32'(bus.group_select), 32'd1);
`endif
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
